// File: rtl/pisa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pisa_pkg
// Description : Shared constants and types for the pixel frame-buffer path
//               (frame writer, frame buffer, VGA reader).
//               PIX_W        - grayscale pixel width
//               WORD_W       - frame-buffer word width
//               PIX_PER_WORD - pixels packed per buffer word
//               fw_state_t   - frame_writer control states
// Revision    : 1.0 - initial release
// ============================================================================
package pisa_pkg;

    localparam int PIX_W        = 8;
    localparam int WORD_W       = 32;
    localparam int PIX_PER_WORD = 4;
    localparam int LANE_W       = $clog2(PIX_PER_WORD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } fw_state_t;

endpackage : pisa_pkg
`default_nettype wire

// File: rtl/pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_packer
// Description : Lane counter plus 4x8 pack register. Incoming pixels are
//               placed little-endian (lane 0 -> bits 7:0). The packed word
//               output already includes the pixel accepted this cycle, so the
//               caller can register it on the same edge the last lane fills.
//               Unfilled lanes always read as zero, which gives the zero-pad
//               for a partial final word for free.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               clear        - restart packing at lane 0 (frame start)
//               accept       - a pixel is taken this cycle
//               flush        - the accepted pixel is the last of the frame
//               pix          - pixel value
//               word_full    - accept lands in the top lane this cycle
//               word         - packed word including this cycle's pixel
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_packer
    import pisa_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic              flush,
    input  logic [PIX_W-1:0]  pix,
    output logic              word_full,
    output logic [WORD_W-1:0] word
);

    logic [WORD_W-1:0] r_pack;
    logic [LANE_W-1:0] r_lane;
    logic [WORD_W-1:0] w_merged;

    always_comb begin
        w_merged = r_pack;
        if (accept) begin
            w_merged[int'(r_lane) * PIX_W +: PIX_W] = pix;
        end
    end

    assign word_full = accept && (r_lane == LANE_W'(PIX_PER_WORD - 1));
    assign word      = w_merged;

    // The register is cleared whenever a word leaves, so the next word
    // starts from all-zero lanes.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_pack <= '0;
            r_lane <= '0;
        end else if (accept) begin
            if (word_full || flush) begin
                r_pack <= '0;
                r_lane <= '0;
            end else begin
                r_pack <= w_merged;
                r_lane <= r_lane + 1'b1;
            end
        end
    end

endmodule : pixel_packer
`default_nettype wire

// File: rtl/frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : frame_writer
// Description : Upstream feeder for the pixel frame buffer. Accepts an 8-bit
//               pixel stream (valid/ready), packs 4 pixels per 32-bit word and
//               drives the buffer write port. One frame per start pulse;
//               done pulses one cycle after the final word write.
// Parameters  : FRAME_PIXELS - pixels per frame (>=1)
//               BASE_ADDR    - word address of the first word
//               ADDR_W       - width of wraddress
// Ports       : clk, reset          - clock, synchronous active-high reset
//               start               - begin a frame (honoured only when idle)
//               pix_valid, pix_data - pixel stream in
//               pix_ready           - pixel accepted this cycle (FILL state)
//               data, wraddress, wren - frame buffer write port
//               busy, done          - frame status
//               checksum            - mod-2^16 pixel sum of the current frame
//                                     (only with FRAME_WRITER_CHECKSUM_EN)
// Options     : `define FRAME_WRITER_CHECKSUM_EN to add the checksum port.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_writer
    import pisa_pkg::*;
#(
    parameter int FRAME_PIXELS = 65536,
    parameter int BASE_ADDR    = 0,
    parameter int ADDR_W       = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    output logic [WORD_W-1:0] data,
    output logic [ADDR_W-1:0] wraddress,
    output logic              wren,
    output logic              busy,
`ifdef FRAME_WRITER_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic              done
);

    localparam int                CNT_W    = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [ADDR_W-1:0] BASE_W   = ADDR_W'(BASE_ADDR);

    fw_state_t         r_state;
    fw_state_t         w_state_next;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_word_idx;
    logic [WORD_W-1:0] r_data;
    logic [ADDR_W-1:0] r_wraddress;
    logic              r_wren;
    logic              r_busy;
    logic              r_done;

    logic              w_start;
    logic              w_accept;
    logic              w_last;
    logic              w_flush;
    logic              w_word_full;
    logic [WORD_W-1:0] w_word;

    assign w_start   = (r_state == IDLE) && start;
    assign pix_ready = (r_state == FILL);
    assign w_accept  = pix_ready && pix_valid;
    assign w_last    = (r_count == LAST_IDX);
    assign w_flush   = w_accept && w_last;

    pixel_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_start),
        .accept    (w_accept),
        .flush     (w_flush),
        .pix       (pix_data),
        .word_full (w_word_full),
        .word      (w_word)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)   w_state_next = FILL;
            FILL:    if (w_flush) w_state_next = FLUSH;
            FLUSH:   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write port, counters and status.
    // A partial final word is written on the same edge as a full one (the
    // packer zero-pads it), so the final write is always visible in the
    // FLUSH cycle and done always follows it by exactly one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_word_idx  <= '0;
            r_data      <= '0;
            r_wraddress <= BASE_W;
            r_wren      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            r_done <= 1'b0;
            if (w_start) begin
                r_busy     <= 1'b1;
                r_count    <= '0;
                r_word_idx <= '0;
            end
            if (w_accept) begin
                r_count <= r_count + 1'b1;
                if (w_word_full || w_last) begin
                    r_wren      <= 1'b1;
                    r_data      <= w_word;
                    r_wraddress <= BASE_W + r_word_idx;
                    r_word_idx  <= r_word_idx + 1'b1;
                end
            end
            if (r_state == FLUSH) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign wraddress = r_wraddress;
    assign wren      = r_wren;
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef FRAME_WRITER_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + 16'(pix_data);
        end
    end

    assign checksum = r_checksum;
`endif

endmodule : frame_writer
`default_nettype wire
